// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants for the instruction fetch memory
package imem_pkg;

    localparam int FAULT_W        = 2;
    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction storage, one sync write port and one sync read port
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on storage or read data so the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_idx) < 32'(DEPTH))) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - sync-read instruction memory with valid/ready fetch and fault flags
module instr_fetch_mem #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = imem_pkg::NOP_INSTR,
    localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_W-1:0]            resp_instr,
    output logic [ADDR_W-1:0]            resp_addr,
    output logic [imem_pkg::FAULT_W-1:0] resp_fault,
    input  logic                         load_en,
    input  logic [IDX_W-1:0]             load_idx,
    input  logic [DATA_W-1:0]            load_data
);

    import imem_pkg::*;

    logic               accept;
    logic [ADDR_W-1:0]  off;
    logic [ADDR_W-1:0]  idx;
    logic [FAULT_W-1:0] fault;
    logic               instr_vld;
    logic [DATA_W-1:0]  rd_data;

    // Loader has priority; the single response stage only frees up when drained.
    assign req_ready = !load_en && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    assign off = req_addr - BASE_ADDR;
    assign idx = off >> 2;

    always_comb begin
        fault                 = '0;
        fault[FAULT_MISALIGN] = (req_addr[1:0] != 2'b00);
        fault[FAULT_RANGE]    = (req_addr < BASE_ADDR) || (idx >= ADDR_W'(DEPTH));
    end

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (load_en),
        .wr_idx  (load_idx),
        .wr_data (load_data),
        .rd_en   (accept && (fault == '0)),
        .rd_idx  (idx[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_fault <= '0;
            instr_vld  <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_addr  <= req_addr;
            resp_fault <= fault;
            instr_vld  <= 1'b1;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // rd_data only moves on a clean accept, so it holds through backpressure and later loads.
    assign resp_instr = (instr_vld && (resp_fault == '0)) ? rd_data : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - directed self-checking bench for instr_fetch_mem
module tb_instr_fetch_mem;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic [1:0]  resp_fault;
    logic        load_en;
    logic [5:0]  load_idx;
    logic [31:0] load_data;

    int checks;
    int failures;

    logic [31:0] prog [4];

    instr_fetch_mem dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_fault (resp_fault),
        .load_en    (load_en),
        .load_idx   (load_idx),
        .load_data  (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input string tag, input logic [31:0] instr,
                              input logic [31:0] addr, input logic [1:0] flt);
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_instr"}, 64'(resp_instr), 64'(instr));
        check({tag, "_addr"},  64'(resp_addr),  64'(addr));
        check({tag, "_fault"}, 64'(resp_fault), 64'(flt));
    endtask

    task automatic fetch_one(input string tag, input logic [31:0] addr,
                             input logic [31:0] instr, input logic [1:0] flt);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        check_resp(tag, instr, addr, flt);
        tick();
        check({tag, "_drain"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        prog[0]    = 32'h0000_8233;
        prog[1]    = 32'h00A0_0093;
        prog[2]    = 32'h0140_0B13;
        prog[3]    = 32'h0000_A383;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b1;
        load_en    = 1'b0;
        load_idx   = '0;
        load_data  = '0;
        tick();
        tick();
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_instr", 64'(resp_instr), 64'h13);
        check("rst_addr",  64'(resp_addr),  64'd0);
        check("rst_fault", 64'(resp_fault), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            load_en   = 1'b1;
            load_idx  = 6'(i);
            load_data = prog[i];
            tick();
        end
        load_en = 1'b0;

        // back-to-back fetches, one response per cycle
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'(4 * i);
            #1;
            check($sformatf("b2b%0d_ready", i), 64'(req_ready), 64'd1);
            tick();
            check_resp($sformatf("b2b%0d", i), prog[i], 32'(4 * i), 2'b00);
        end
        req_valid = 1'b0;
        tick();
        check("b2b_drain", 64'(resp_valid), 64'd0);

        fetch_one("mis6",   32'd6,   32'h13, 2'b01);
        fetch_one("rng256", 32'd256, 32'h13, 2'b10);
        fetch_one("both258", 32'd258, 32'h13, 2'b11);

        // backpressure hold with a queued request behind it
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'd4;
        tick();
        req_addr = 32'd8;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("hold%0d_ready", c), 64'(req_ready), 64'd0);
            check_resp($sformatf("hold%0d", c), prog[1], 32'd4, 2'b00);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("release_ready", 64'(req_ready), 64'd1);
        tick();
        check_resp("queued", prog[2], 32'd8, 2'b00);
        req_valid = 1'b0;
        tick();
        check("queued_drain", 64'(resp_valid), 64'd0);

        // loader blocks fetch, then the new word is visible
        load_en   = 1'b1;
        load_idx  = 6'd1;
        load_data = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'd0;
        #1;
        check("load_ready", 64'(req_ready), 64'd0);
        tick();
        check("load_noresp", 64'(resp_valid), 64'd0);
        load_en  = 1'b0;
        req_addr = 32'd4;
        tick();
        check_resp("reload", 32'hDEAD_BEEF, 32'd4, 2'b00);
        req_valid = 1'b0;
        tick();

        // asynchronous reset mid-response
        req_valid = 1'b1;
        req_addr  = 32'd8;
        tick();
        req_valid = 1'b0;
        check("pre_rst_valid", 64'(resp_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(resp_valid), 64'd0);
        check("async_rst_instr", 64'(resp_instr), 64'h13);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_valid", 64'(resp_valid), 64'd0);
        check("post_rst_addr",  64'(resp_addr),  64'd0);
        fetch_one("keep12", 32'd12, prog[3], 2'b00);
        fetch_one("keep4",  32'd4,  32'hDEAD_BEEF, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
